// File: rtl/matrix_multiply.sv
// 5x5 signed matrix multiplier: streams in A then B, computes C = A*B with a single
// MAC unit (5 cycles per element), then streams C out row-major with valid/ready.
module matrix_multiply #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_idx,
  output logic          busy
);

  typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

  state_e        state_q;
  logic [5:0]    load_cnt_q;
  logic [2:0]    row_q, col_q, k_q;
  logic [4:0]    elem_q;
  logic [DW-1:0] acc_q;

  logic [DW-1:0] a_mem [25];
  logic [DW-1:0] b_mem [25];
  logic [DW-1:0] c_mem [25];

  logic          in_fire;
  logic [5:0]    load_off;
  logic [4:0]    load_idx;
  logic [4:0]    a_idx, b_idx;
  logic [DW-1:0] prod, mac;

  // in_ready is only ever high in StLoad, so it alone qualifies a transfer.
  assign in_fire = in_valid && in_ready;

  always_comb begin
    load_off = (load_cnt_q < 6'd25) ? load_cnt_q : load_cnt_q - 6'd25;
    load_idx = load_off[4:0];
    a_idx    = 5'(row_q) * 5'd5 + 5'(k_q);
    b_idx    = 5'(k_q) * 5'd5 + 5'(col_q);
    // Low DW bits of a product are identical for signed and unsigned operands.
    prod     = a_mem[a_idx] * b_mem[b_idx];
    mac      = ((k_q == 3'd0) ? '0 : acc_q) + prod;
  end

  // Storage needs no reset: C is always fully rewritten before it is read out.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (load_cnt_q < 6'd25) begin
        a_mem[load_idx] <= in_data;
      end else begin
        b_mem[load_idx] <= in_data;
      end
    end
    if (state_q == StCompute && k_q == 3'd4) begin
      c_mem[elem_q] <= mac;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      load_cnt_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      elem_q     <= '0;
      acc_q      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_fire) begin
            if (load_cnt_q == 6'd49) begin
              load_cnt_q <= '0;
              state_q    <= StCompute;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
            end else begin
              load_cnt_q <= load_cnt_q + 6'd1;
            end
          end
        end
        StCompute: begin
          acc_q <= mac;
          if (k_q == 3'd4) begin
            k_q    <= '0;
            elem_q <= elem_q + 5'd1;
            if (col_q == 3'd4) begin
              col_q <= '0;
              if (row_q == 3'd4) begin
                row_q     <= '0;
                elem_q    <= '0;
                state_q   <= StOutput;
                out_valid <= 1'b1;
                out_idx   <= '0;
                out_data  <= c_mem[0];
              end else begin
                row_q <= row_q + 3'd1;
              end
            end else begin
              col_q <= col_q + 3'd1;
            end
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        StOutput: begin
          if (out_valid && out_ready) begin
            if (out_idx == 5'd24) begin
              state_q   <= StLoad;
              out_valid <= 1'b0;
              out_idx   <= '0;
              out_data  <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_idx  <= out_idx + 5'd1;
              out_data <= c_mem[out_idx + 5'd1];
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_multiply.sv
// Self-checking bench for matrix_multiply: directed matrices, random gaps/backpressure,
// mid-compute reset and garbage input during compute/output, checked against a golden model.
module tb_matrix_multiply;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        busy;

  matrix_multiply #(.DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] a_m [25];
  logic [31:0] b_m [25];
  logic [31:0] exp_c [25];
  logic [31:0] got [25];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_in_cyc = 0;
  int first_out_cyc = -1;
  int first_x_cyc = 0;
  int last_x_cyc = 0;
  int in_xfers = 0;
  int xfers = 0;
  int exp_idx = 0;
  bit seen_first = 0;
  bit expect_out = 1;
  bit stalled_prev = 0;
  logic [31:0] held_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Golden model: plain 5x5 matrix product, wrapping modulo 2^32.
  task automatic compute_model();
    logic [31:0] sum;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        sum = '0;
        for (int k = 0; k < 5; k++) sum = sum + a_m[i*5+k] * b_m[k*5+j];
        exp_c[i*5+j] = sum;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        last_in_cyc = cyc;
        in_xfers++;
      end
      stalled_prev = out_valid && !out_ready;
      held_data    = out_data;
      if (out_valid && out_ready) begin
        if (xfers == 0) first_x_cyc = cyc;
        last_x_cyc   = cyc;
        got[out_idx] = out_data;
        xfers++;
        exp_idx++;
      end
    end else begin
      stalled_prev = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!seen_first) begin
        seen_first    = 1;
        first_out_cyc = cyc;
      end
      if (!expect_out) begin
        check("out_valid_after_abort", out_valid, 1'b0);
      end else if (exp_idx > 24) begin
        check("output_count_overrun", exp_idx, 24);
      end else begin
        check("out_idx", out_idx, exp_idx);
        check("out_data", out_data, exp_c[exp_idx]);
        if (stalled_prev) check("stall_hold", out_data, held_data);
      end
    end
  end

  task automatic load(input bit gaps);
    for (int n = 0; n < 50; n++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      in_data  = (n < 25) ? a_m[n] : b_m[n-25];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input bit gaps, input bit rand_ready, input bit garbage);
    compute_model();
    exp_idx = 0;
    xfers = 0;
    in_xfers = 0;
    seen_first = 0;
    first_out_cyc = -1;
    expect_out = 1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    load(gaps);
    check("in_xfers", in_xfers, 50);
    check("busy_in_compute", busy, 1'b1);
    check("in_ready_in_compute", in_ready, 1'b0);
    check("out_valid_in_compute", out_valid, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      if (garbage) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (xfers >= 25) break;
    end
    in_valid = 1'b0;
    check("out_xfers", xfers, 25);
    check("first_out_latency", first_out_cyc - last_in_cyc, 125);
    if (!rand_ready) check("drain_span", last_x_cyc - first_x_cyc, 24);
    check("out_valid_after_op", out_valid, 1'b0);
    check("in_ready_after_op", in_ready, 1'b1);
    check("busy_after_op", busy, 1'b0);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_mats();
    for (int n = 0; n < 25; n++) begin
      a_m[n] = $urandom;
      b_m[n] = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_idx", out_idx, 5'd0);
    check("rst_out_data", out_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Identity x counting matrix -> 1..25.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        a_m[r*5+c] = (r == c) ? 32'd1 : 32'd0;
        b_m[r*5+c] = 32'(5*r + c + 1);
      end
    run_op(0, 0, 0);
    for (int n = 0; n < 25; n++) check("ident_lit", got[n], 32'(n + 1));

    // Row-scaled A times all-ones B -> 5(r+1) across row r.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        a_m[r*5+c] = 32'(r + 1);
        b_m[r*5+c] = 32'd1;
      end
    run_op(0, 0, 0);
    for (int n = 0; n < 25; n++) check("rows_lit", got[n], 32'(5 * (n/5 + 1)));

    // 5 * 2^32 wraps to zero.
    for (int n = 0; n < 25; n++) begin
      a_m[n] = 32'h0001_0000;
      b_m[n] = 32'h0001_0000;
    end
    run_op(0, 0, 0);
    for (int n = 0; n < 25; n += 6) check("wrap_lit", got[n], 32'd0);

    // All -1 times identity -> all -1.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        a_m[r*5+c] = 32'hFFFF_FFFF;
        b_m[r*5+c] = (r == c) ? 32'd1 : 32'd0;
      end
    run_op(0, 0, 0);
    for (int n = 0; n < 25; n += 6) check("neg_lit", got[n], 32'hFFFF_FFFF);

    // Random data with input gaps and random backpressure.
    rand_mats();
    run_op(1, 1, 0);
    rand_mats();
    run_op(1, 1, 0);

    // Reset at COMPUTE cycle 60 abandons the operation.
    rand_mats();
    in_xfers = 0;
    expect_out = 0;
    load(0);
    repeat (60) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_out_idx", out_idx, 5'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_idle_busy", busy, 1'b0);
    rand_mats();
    run_op(0, 1, 0);

    // Garbage on in_valid/in_data during COMPUTE and OUTPUT, then a clean load.
    rand_mats();
    run_op(0, 1, 1);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        a_m[r*5+c] = 32'(r*5 + c + 1);
        b_m[r*5+c] = (r == c) ? 32'd1 : 32'd0;
      end
    run_op(0, 0, 0);
    check("after_garbage_a11", got[0], 32'd1);
    check("after_garbage_a55", got[24], 32'd25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
